accumulator_bank: RTL and testbench
===================================

# accumulator_bank

Multi-entry successor to the single-row column accumulator. It holds ACC_DEPTH independent rows of ARR_SIZE signed column sums, fed from the bottom of the systolic array. On command it drains one row word-by-word into the output buffer under a valid/ready handshake. It adds selectable saturation, per-row addressing and output back-pressure, none of which the single-row accumulator supports.

## Interface
- ARR_SIZE, 4, number of columns (lanes) per row
- VERTICAL_BW, 32, lane width in bits; signed two's complement
- ACC_DEPTH, 4, number of accumulator rows; power of two, ≥2
- ADDR_BW, 4, output-buffer address width
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  accumulate request this cycle
- in_entry  in  $clog2(ACC_DEPTH)  target row for the accumulate
- accumulated_val  in  ARR_SIZE*VERTICAL_BW  lane i is at bits [i*VERTICAL_BW +: VERTICAL_BW]
- acc_reset  in  1  qualified by in_valid; row is loaded with accumulated_val instead of summed
- store_output  in  1  drain request
- store_entry  in  $clog2(ACC_DEPTH)  row to drain
- op_buffer_address  in  ADDR_BW  base address of the drain
- store_ready  out  1  drain request is accepted when store_output && store_ready
- output_data  out  VERTICAL_BW  current drain word
- output_buffer_addr  out  ADDR_BW  address of the current word
- output_buffer_enable  out  1  word valid
- output_buffer_ready  in  1  output buffer accepts the word
- sat_flag  out  1  sticky overflow indicator

## Operation
- **Accumulate** (in_valid=1): for each lane, row[in_entry][i] ← acc_reset ? val[i] : row[in_entry][i] + val[i].
  - Sum is computed at VERTICAL_BW+1 bits, signed.
  - Overflow occurs when the sum falls outside the signed VERTICAL_BW range.
  - SATURATE=1: clamp to 0x7FFF_FFFF / 0x8000_0000 (shown for 32 bits).
  - SATURATE=0: keep the low VERTICAL_BW bits.
  - Either mode: any lane overflow sets sat_flag. It clears only on rst.
  - acc_reset never overflows.
- **Drain FSM.** States are IDLE and DRAIN.
  - IDLE: store_ready=1. On store_output, snapshot row[store_entry] into a shadow register, latch the base address, set beat=0, go to DRAIN.
  - DRAIN: output_buffer_enable=1, output_data = shadow lane[beat], output_buffer_addr = base+beat, taken modulo 2^ADDR_BW (wraps).
  - A beat completes when output_buffer_enable && output_buffer_ready. beat then increments.
  - After lane ARR_SIZE-1 completes, go to IDLE.
  - Lane 0 is sent first.
  - The drained row is not modified.
- **Simultaneous events.**
  - Accumulate into the same row in the accept cycle: the snapshot holds the pre-add value. The add still lands.
  - Accumulates to any row continue during DRAIN.
  - store_output while in DRAIN is ignored; the requester must hold it until it sees store_ready.

## Timing
- Reset values:
  - All rows, shadow, beat and base: 0.
  - State: IDLE.
  - store_ready: 1.
  - output_data, output_buffer_addr, output_buffer_enable, sat_flag: 0.
- Accumulate latency: 1 cycle. The row holds the new value on the edge after in_valid.
- Drain latency: beat 0 is valid in the cycle after the accept edge.
- With output_buffer_ready held at 1: ARR_SIZE consecutive beats, then store_ready=1 on the next cycle. Throughput is ARR_SIZE+1 cycles per drain.
- Back-pressure: while output_buffer_ready=0, output_data, output_buffer_addr and output_buffer_enable hold stable.
- All outputs are registered.
- rst asserted mid-drain: the drain is abandoned immediately (asynchronous), output_buffer_enable drops to 0, and all rows clear.

## Structure
- Shared package `acc_pkg`:
  - drain-state enum
  - saturation constants, parameterised by VERTICAL_BW
  - lane slice helper function
- Sub-module `acc_lane_add`: one signed add with acc_reset select, clamp/wrap and overflow output. Instantiated ARR_SIZE times via generate.
- The row array and drain FSM live in the top module.

## Test plan
- Accumulate with acc_reset: rst release; row 1 loaded with acc_reset {40,30,20,10} (lane3..lane0), then summed with {35,25,15,5}. Drain with base 0xA and ready=1 → beats 15@0xA, 35@0xB, 55@0xC, 75@0xD on 4 consecutive cycles; store_ready returns 1 on the following cycle.
- Saturation, SATURATE=1: row 0 lane 0 at 0x7FFF_FFF0 plus 0x20 → lane holds 0x7FFF_FFFF and sat_flag=1. Same stimulus with SATURATE=0 → 0x8000_0010 and sat_flag=1.
- Back-pressure: drain with output_buffer_ready low on beats 1–2 for 3 cycles → output_data and output_buffer_addr stable throughout; no beat lost or duplicated.
- Address wrap and snapshot: drain with base 0xE → addresses 0xE, 0xF, 0x0, 0x1. Accumulate into the draining row during the accept cycle → drained data is the pre-add value; the row holds the post-add value.
- Reset mid-drain: rst low during beat 2 → output_buffer_enable=0 asynchronously; after release all rows read 0 and store_ready=1.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator bank: drain FSM states,
// signed saturation limits for a given lane width, and a lane extractor
// for packed multi-lane vectors (lane i at bits [i*bw +: bw]).
package acc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Widest lane / packed vector the helpers can handle.
  localparam int unsigned MAX_LANE_BW = 64;
  localparam int unsigned MAX_VEC_BW  = 1024;

  // Most positive signed value of width bw (low bw bits are meaningful).
  function automatic logic [MAX_LANE_BW-1:0] sat_max(input int unsigned bw);
    return (MAX_LANE_BW'(1) << (bw - 1)) - MAX_LANE_BW'(1);
  endfunction

  // Most negative signed value of width bw (low bw bits are meaningful).
  function automatic logic [MAX_LANE_BW-1:0] sat_min(input int unsigned bw);
    return MAX_LANE_BW'(1) << (bw - 1);
  endfunction

  // Returns lane 'lane' of a packed vector; caller truncates to bw bits.
  function automatic logic [MAX_LANE_BW-1:0] lane_of(input logic [MAX_VEC_BW-1:0] vec,
                                                     input int unsigned lane,
                                                     input int unsigned bw);
    return MAX_LANE_BW'(vec >> (lane * bw));
  endfunction

endpackage

// File: rtl/acc_lane_add.sv
// One accumulator lane: signed add (or load when load_i), clamp or wrap on overflow.
// Ports: acc_i current lane value, val_i addend, load_i selects load instead of add,
//        sum_o next lane value, ovf_o high when the add left the signed range.
module acc_lane_add
  import acc_pkg::*;
#(
  parameter int unsigned VERTICAL_BW = 32,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic [VERTICAL_BW-1:0] acc_i,
  input  logic [VERTICAL_BW-1:0] val_i,
  input  logic                   load_i,
  output logic [VERTICAL_BW-1:0] sum_o,
  output logic                   ovf_o
);

  localparam logic [VERTICAL_BW-1:0] POS_MAX = VERTICAL_BW'(sat_max(VERTICAL_BW));
  localparam logic [VERTICAL_BW-1:0] NEG_MIN = VERTICAL_BW'(sat_min(VERTICAL_BW));

  logic [VERTICAL_BW:0] sum_wide;
  logic                 ovf;

  always_comb begin
    // Sign-extend both operands so the extra bit captures the true sign.
    sum_wide = {acc_i[VERTICAL_BW-1], acc_i} + {val_i[VERTICAL_BW-1], val_i};
    // Result fits only when the two top bits agree.
    ovf      = sum_wide[VERTICAL_BW] ^ sum_wide[VERTICAL_BW-1];
    sum_o    = sum_wide[VERTICAL_BW-1:0];
    ovf_o    = 1'b0;
    if (load_i) begin
      sum_o = val_i;
    end else begin
      ovf_o = ovf;
      if (ovf && SATURATE) begin
        sum_o = sum_wide[VERTICAL_BW] ? NEG_MIN : POS_MAX;
      end
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// ACC_DEPTH rows of ARR_SIZE signed column sums; one row is drained lane by lane
// to the output buffer under a valid/ready handshake.
// Ports: accumulate (in_valid/in_entry/accumulated_val/acc_reset), drain request
//        (store_output/store_entry/op_buffer_address/store_ready), output buffer
//        write (output_data/output_buffer_addr/output_buffer_enable/output_buffer_ready),
//        sticky sat_flag. All outputs registered.
module accumulator_bank
  import acc_pkg::*;
#(
  parameter int unsigned ARR_SIZE    = 4,
  parameter int unsigned VERTICAL_BW = 32,
  parameter int unsigned ACC_DEPTH   = 4,
  parameter int unsigned ADDR_BW     = 4,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [$clog2(ACC_DEPTH)-1:0]    in_entry,
  input  logic [ARR_SIZE*VERTICAL_BW-1:0] accumulated_val,
  input  logic                            acc_reset,
  input  logic                            store_output,
  input  logic [$clog2(ACC_DEPTH)-1:0]    store_entry,
  input  logic [ADDR_BW-1:0]              op_buffer_address,
  output logic                            store_ready,
  output logic [VERTICAL_BW-1:0]          output_data,
  output logic [ADDR_BW-1:0]              output_buffer_addr,
  output logic                            output_buffer_enable,
  input  logic                            output_buffer_ready,
  output logic                            sat_flag
);

  localparam int unsigned ROW_BW  = ARR_SIZE * VERTICAL_BW;
  localparam int unsigned BEAT_BW = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [BEAT_BW-1:0] LAST_BEAT = BEAT_BW'(ARR_SIZE - 1);

  // ---------------- row array and lane adders ----------------
  logic [ROW_BW-1:0]   row_q [ACC_DEPTH];
  logic [ROW_BW-1:0]   cur_row;
  logic [ROW_BW-1:0]   sum_row;
  logic [ARR_SIZE-1:0] lane_ovf;
  logic                sat_q;

  assign cur_row = row_q[in_entry];

  for (genvar g = 0; g < ARR_SIZE; g++) begin : g_lane
    logic [VERTICAL_BW-1:0] val_lane;
    assign val_lane = VERTICAL_BW'(lane_of(MAX_VEC_BW'(accumulated_val), g, VERTICAL_BW));

    acc_lane_add #(
      .VERTICAL_BW(VERTICAL_BW),
      .SATURATE   (SATURATE)
    ) u_add (
      .acc_i (cur_row[g*VERTICAL_BW +: VERTICAL_BW]),
      .val_i (val_lane),
      .load_i(acc_reset),
      .sum_o (sum_row[g*VERTICAL_BW +: VERTICAL_BW]),
      .ovf_o (lane_ovf[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ACC_DEPTH; r++) row_q[r] <= '0;
      sat_q <= 1'b0;
    end else if (in_valid) begin
      row_q[in_entry] <= sum_row;
      sat_q           <= sat_q | (|lane_ovf);
    end
  end

  // ---------------- drain FSM ----------------
  drain_state_e           state_q, state_d;
  logic [ROW_BW-1:0]      shadow_q, shadow_d;
  logic [ADDR_BW-1:0]     base_q, base_d;
  logic [BEAT_BW-1:0]     beat_q, beat_d;
  logic [VERTICAL_BW-1:0] data_q, data_d;
  logic [ADDR_BW-1:0]     addr_q, addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      base_q   <= '0;
      beat_q   <= '0;
      data_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    base_d   = base_q;
    beat_d   = beat_q;
    data_d   = data_q;
    addr_d   = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (store_output) begin
          // Snapshot reads the pre-update row, so a same-cycle add is not seen.
          state_d  = ST_DRAIN;
          shadow_d = row_q[store_entry];
          base_d   = op_buffer_address;
          beat_d   = '0;
          data_d   = VERTICAL_BW'(lane_of(MAX_VEC_BW'(row_q[store_entry]), 0, VERTICAL_BW));
          addr_d   = op_buffer_address;
        end
      end
      ST_DRAIN: begin
        if (output_buffer_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_BW'(1);
            data_d = VERTICAL_BW'(lane_of(MAX_VEC_BW'(shadow_q), int'(beat_d), VERTICAL_BW));
            // Address wraps naturally at ADDR_BW bits.
            addr_d = base_q + ADDR_BW'(beat_d);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    store_ready          = (state_q == ST_IDLE);
    output_buffer_enable = (state_q == ST_DRAIN);
    output_data          = data_q;
    output_buffer_addr   = addr_q;
    sat_flag             = sat_q;
  end

endmodule

// File: tb/tb_accumulator_bank.sv
module tb_accumulator_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   in_entry;
  logic [127:0] accumulated_val;
  logic         acc_reset;
  logic         store_output;
  logic [1:0]   store_entry;
  logic [3:0]   op_buffer_address;
  logic         output_buffer_ready;

  logic         store_ready0, store_ready1;
  logic [31:0]  data0, data1;
  logic [3:0]   addr0, addr1;
  logic         en0, en1;
  logic         sat0, sat1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  accumulator_bank #(.ARR_SIZE(4), .VERTICAL_BW(32), .ACC_DEPTH(4), .ADDR_BW(4), .SATURATE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_entry(in_entry),
    .accumulated_val(accumulated_val), .acc_reset(acc_reset),
    .store_output(store_output), .store_entry(store_entry),
    .op_buffer_address(op_buffer_address), .store_ready(store_ready0),
    .output_data(data0), .output_buffer_addr(addr0),
    .output_buffer_enable(en0), .output_buffer_ready(output_buffer_ready),
    .sat_flag(sat0)
  );

  accumulator_bank #(.ARR_SIZE(4), .VERTICAL_BW(32), .ACC_DEPTH(4), .ADDR_BW(4), .SATURATE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_entry(in_entry),
    .accumulated_val(accumulated_val), .acc_reset(acc_reset),
    .store_output(store_output), .store_entry(store_entry),
    .op_buffer_address(op_buffer_address), .store_ready(store_ready1),
    .output_data(data1), .output_buffer_addr(addr1),
    .output_buffer_enable(en1), .output_buffer_ready(output_buffer_ready),
    .sat_flag(sat1)
  );

  typedef struct {
    bit           is_drain;
    logic [1:0]   entry;
    logic         acc_rst;
    logic [127:0] val;
    logic [3:0]   base;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic acc_op(input logic [1:0] e, input logic r, input logic [127:0] v);
    in_valid        = 1'b1;
    in_entry        = e;
    acc_reset       = r;
    accumulated_val = v;
    step();
    in_valid  = 1'b0;
    acc_reset = 1'b0;
  endtask

  task automatic check_beat(input int k, input logic [3:0] ea,
                            input logic [127:0] x0, input logic [127:0] x1);
    chk($sformatf("beat%0d_en", k), en0, 1);
    chk($sformatf("beat%0d_ready_low", k), store_ready0, 0);
    chk($sformatf("beat%0d_data_sat", k), data0, x0[k*32 +: 32]);
    chk($sformatf("beat%0d_data_wrap", k), data1, x1[k*32 +: 32]);
    chk($sformatf("beat%0d_addr", k), addr0, ea);
  endtask

  // Drain one row; stall[k] holds output_buffer_ready low for 3 cycles on beat k.
  task automatic do_drain(input logic [1:0] e, input logic [3:0] b,
                          input logic [127:0] x0, input logic [127:0] x1,
                          input logic [3:0] stall, input bit acc_same,
                          input logic [127:0] acc_v);
    logic [3:0] ea;
    store_output        = 1'b1;
    store_entry         = e;
    op_buffer_address   = b;
    output_buffer_ready = 1'b1;
    chk("accept_ready", store_ready0, 1);
    if (acc_same) begin
      in_valid        = 1'b1;
      in_entry        = e;
      acc_reset       = 1'b0;
      accumulated_val = acc_v;
    end
    step();
    store_output = 1'b0;
    in_valid     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ea = b + 4'(k);
      for (int s = 0; s < (stall[k] ? 3 : 0); s++) begin
        output_buffer_ready = 1'b0;
        check_beat(k, ea, x0, x1);
        step();
      end
      output_buffer_ready = 1'b1;
      check_beat(k, ea, x0, x1);
      step();
    end
    chk("done_ready", store_ready0, 1);
    chk("done_en", en0, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd1, 1'b1, {32'd40, 32'd30, 32'd20, 32'd10}, 4'h0, 128'd0};
    vecs[1] = '{1'b0, 2'd1, 1'b0, {32'd35, 32'd25, 32'd15, 32'd5}, 4'h0, 128'd0};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 128'd0, 4'hA, {32'd75, 32'd55, 32'd35, 32'd15}};
    vecs[3] = '{1'b0, 2'd2, 1'b1, {-32'd1, -32'd100, 32'd7, 32'h1000}, 4'h0, 128'd0};
    vecs[4] = '{1'b0, 2'd2, 1'b0, {32'd1, 32'd50, -32'd10, 32'h10}, 4'h0, 128'd0};
    vecs[5] = '{1'b0, 2'd3, 1'b0, {32'd3, 32'd2, 32'd1, 32'd0}, 4'h0, 128'd0};
    vecs[6] = '{1'b1, 2'd2, 1'b0, 128'd0, 4'h0, {32'd0, -32'd50, -32'd3, 32'h1010}};
    vecs[7] = '{1'b1, 2'd3, 1'b0, 128'd0, 4'h5, {32'd3, 32'd2, 32'd1, 32'd0}};
    vecs[8] = '{1'b1, 2'd1, 1'b0, 128'd0, 4'hE, {32'd75, 32'd55, 32'd35, 32'd15}};

    rst                 = 1'b0;
    in_valid            = 1'b0;
    in_entry            = '0;
    accumulated_val     = '0;
    acc_reset           = 1'b0;
    store_output        = 1'b0;
    store_entry         = '0;
    op_buffer_address   = '0;
    output_buffer_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    step();

    chk("rst_store_ready", store_ready0, 1);
    chk("rst_en", en0, 0);
    chk("rst_data", data0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_sat_flag0", sat0, 0);
    chk("rst_sat_flag1", sat1, 0);

    // Table: accumulates, plain drains, re-drain of an already drained row with wrap.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_drain)
        do_drain(vecs[i].entry, vecs[i].base, vecs[i].exp, vecs[i].exp, 4'b0000, 1'b0, 128'd0);
      else
        acc_op(vecs[i].entry, vecs[i].acc_rst, vecs[i].val);
    end
    chk("no_ovf_sat0", sat0, 0);
    chk("no_ovf_sat1", sat1, 0);

    // Back-pressure on beats 1 and 2.
    do_drain(2'd1, 4'h3, {32'd75, 32'd55, 32'd35, 32'd15},
             {32'd75, 32'd55, 32'd35, 32'd15}, 4'b0110, 1'b0, 128'd0);

    // Add into row 2 in the accept cycle: drain shows pre-add, row keeps post-add.
    do_drain(2'd2, 4'h8, {32'd0, -32'd50, -32'd3, 32'h1010},
             {32'd0, -32'd50, -32'd3, 32'h1010}, 4'b0000, 1'b1,
             {32'd1, 32'd1, 32'd1, 32'd1});
    do_drain(2'd2, 4'h0, {32'd1, -32'd49, -32'd2, 32'h1011},
             {32'd1, -32'd49, -32'd2, 32'h1011}, 4'b0000, 1'b0, 128'd0);

    // Positive and negative overflow in row 0.
    acc_op(2'd0, 1'b1, {32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFF0});
    chk("load_no_sat0", sat0, 0);
    chk("load_no_sat1", sat1, 0);
    acc_op(2'd0, 1'b0, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0000_0020});
    chk("ovf_sat_flag0", sat0, 1);
    chk("ovf_sat_flag1", sat1, 1);
    do_drain(2'd0, 4'h0, {32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF},
             {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h8000_0010}, 4'b0000, 1'b0, 128'd0);
    chk("sat_flag_sticky", sat0, 1);

    // Reset in the middle of a drain.
    store_output        = 1'b1;
    store_entry         = 2'd1;
    op_buffer_address   = 4'h0;
    output_buffer_ready = 1'b1;
    step();
    store_output = 1'b0;
    chk("mid_beat0", data0, 15);
    step();
    step();
    chk("mid_beat2", data0, 55);
    chk("mid_beat2_en", en0, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_en0", en0, 0);
    chk("async_rst_en1", en1, 0);
    chk("async_rst_ready", store_ready0, 1);
    #1 rst = 1'b1;
    step();
    chk("post_rst_ready", store_ready1, 1);
    chk("post_rst_data", data0, 0);
    chk("post_rst_addr", addr1, 0);
    chk("post_rst_sat0", sat0, 0);
    chk("post_rst_sat1", sat1, 0);
    for (int r = 0; r < 4; r++)
      do_drain(2'(r), 4'h0, 128'd0, 128'd0, 4'b0000, 1'b0, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
